// File: rtl/cmos_pkg.sv
// Shared constants and FSM encoding for the two-channel CMOS frame writer.
package cmos_pkg;

  localparam int          BURST_LEN   = 16;
  localparam int          FRAME_BYTES = 1843200;
  localparam logic [27:0] CH0_BASE    = 28'h0000000;
  localparam logic [27:0] CH1_BASE    = 28'h0400000;
  localparam logic [27:0] BUF_STRIDE  = 28'h0200000;

  localparam int ADDR_W = 28;
  localparam int OFS_W  = 21;
  localparam int CNT_W  = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } wr_state_t;

endpackage

// File: rtl/cmos_wr_chan_ctx.sv
// Per-channel write context: frame offset, double-buffer select, pending
// frame-start and sticky overrun flag. Produces the channel's eligibility
// and the byte address of its next burst.
module cmos_wr_chan_ctx #(
  parameter int          BURST_LEN   = cmos_pkg::BURST_LEN,
  parameter int          FRAME_BYTES = cmos_pkg::FRAME_BYTES,
  parameter logic [27:0] BASE        = cmos_pkg::CH0_BASE,
  parameter logic [27:0] BUF_STRIDE  = cmos_pkg::BUF_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_start,
  input  logic [10:0] fifo_cnt,
  input  logic        busy,
  input  logic        burst_done,
  output logic        eligible,
  output logic [27:0] addr,
  output logic        buf_idx,
  output logic        ovf
);
  import cmos_pkg::*;

  localparam int            EW        = OFS_W + 1;
  localparam logic [EW-1:0] STEP      = EW'(2 * BURST_LEN);
  localparam logic [EW-1:0] FRAME_LIM = EW'(FRAME_BYTES);

  logic [OFS_W-1:0] offset;
  logic             wbuf;
  logic             pending;
  logic [EW-1:0]    next_end;
  logic             frame_full;
  logic             cnt_ok;
  logic             restart;

  // A burst may only start if it fits entirely inside the frame.
  assign next_end   = {1'b0, offset} + STEP;
  assign frame_full = next_end > FRAME_LIM;
  assign cnt_ok     = fifo_cnt >= CNT_W'(BURST_LEN);

  // A raw frame-start pulse is treated like a pending one so that a grant
  // and a buffer swap can never land on the same edge.
  assign eligible = en && cnt_ok && !frame_full && !pending && !frame_start;
  assign addr     = BASE + (wbuf ? BUF_STRIDE : '0) + {{(ADDR_W-OFS_W){1'b0}}, offset};

  // Frame restart is deferred while this channel owns the bus.
  assign restart = !busy && (frame_start || pending);

  // Offset, buffer toggling, pending frame-start and overrun bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset  <= '0;
      wbuf    <= 1'b0;
      buf_idx <= 1'b1;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (restart) begin
        offset  <= '0;
        wbuf    <= ~wbuf;
        buf_idx <= wbuf;
        pending <= 1'b0;
      end else begin
        if (burst_done) offset <= next_end[OFS_W-1:0];
        if (frame_start) pending <= 1'b1;
      end
      if (frame_full && cnt_ok) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/cmos_wr_arbiter.sv
// Two-channel round-robin write arbiter: moves BURST_LEN-word bursts from
// two FWFT pixel FIFOs into a memory command/data interface.
//
// Handshake: a command transfers on a cycle where cmd_valid && cmd_ready;
// a data beat transfers on a cycle where wd_valid && wd_ready. Once valid
// is raised, valid and its payload stay stable until the transfer happens.
module cmos_wr_arbiter #(
  parameter int          BURST_LEN   = cmos_pkg::BURST_LEN,
  parameter int          FRAME_BYTES = cmos_pkg::FRAME_BYTES,
  parameter logic [27:0] CH0_BASE    = cmos_pkg::CH0_BASE,
  parameter logic [27:0] CH1_BASE    = cmos_pkg::CH1_BASE,
  parameter logic [27:0] BUF_STRIDE  = cmos_pkg::BUF_STRIDE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_en,
  input  logic        ch0_frame_start,
  input  logic [10:0] ch0_fifo_cnt,
  input  logic [15:0] ch0_rd_data,
  output logic        ch0_rd_en,
  output logic        ch0_buf,
  output logic        ch0_ovf,
  input  logic        ch1_en,
  input  logic        ch1_frame_start,
  input  logic [10:0] ch1_fifo_cnt,
  input  logic [15:0] ch1_rd_data,
  output logic        ch1_rd_en,
  output logic        ch1_buf,
  output logic        ch1_ovf,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [27:0] cmd_addr,
  output logic [7:0]  cmd_len,
  output logic        wd_valid,
  input  logic        wd_ready,
  output logic [15:0] wd_data,
  output logic        wd_last,
  output logic [1:0]  fsm_state
);
  import cmos_pkg::*;

  localparam int               BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [7:0]        LEN_M1    = 8'(BURST_LEN - 1);

  wr_state_t         state;
  logic              grant;
  logic              last_grant;
  logic [BEAT_W-1:0] beat;
  logic              elig0, elig1;
  logic [27:0]       addr0, addr1;
  logic              pick;
  logic              beat_fire;
  logic              burst_end;
  logic              busy0, busy1;

  assign fsm_state = state;

  // Round-robin: on a tie the channel not granted last time wins.
  assign pick = (elig0 && elig1) ? ~last_grant : elig1;

  assign beat_fire = wd_valid && wd_ready;
  assign burst_end = beat_fire && wd_last;
  assign busy0     = (state != ST_IDLE) && !grant;
  assign busy1     = (state != ST_IDLE) && grant;

  // Data path passes the granted FIFO head straight through; pops follow beats.
  assign wd_data   = grant ? ch1_rd_data : ch0_rd_data;
  assign ch0_rd_en = beat_fire && !grant;
  assign ch1_rd_en = beat_fire && grant;

  cmos_wr_chan_ctx #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_BYTES(FRAME_BYTES),
    .BASE       (CH0_BASE),
    .BUF_STRIDE (BUF_STRIDE)
  ) u_ctx0 (
    .clk        (clk),
    .rst        (rst),
    .en         (ch0_en),
    .frame_start(ch0_frame_start),
    .fifo_cnt   (ch0_fifo_cnt),
    .busy       (busy0),
    .burst_done (burst_end && !grant),
    .eligible   (elig0),
    .addr       (addr0),
    .buf_idx    (ch0_buf),
    .ovf        (ch0_ovf)
  );

  cmos_wr_chan_ctx #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_BYTES(FRAME_BYTES),
    .BASE       (CH1_BASE),
    .BUF_STRIDE (BUF_STRIDE)
  ) u_ctx1 (
    .clk        (clk),
    .rst        (rst),
    .en         (ch1_en),
    .frame_start(ch1_frame_start),
    .fifo_cnt   (ch1_fifo_cnt),
    .busy       (busy1),
    .burst_done (burst_end && grant),
    .eligible   (elig1),
    .addr       (addr1),
    .buf_idx    (ch1_buf),
    .ovf        (ch1_ovf)
  );

  // Burst sequencer: grant in IDLE, issue command, stream BURST_LEN beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat       <= '0;
      cmd_valid  <= 1'b0;
      cmd_addr   <= '0;
      cmd_len    <= '0;
      wd_valid   <= 1'b0;
      wd_last    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (elig0 || elig1) begin
            grant      <= pick;
            last_grant <= pick;
            cmd_addr   <= pick ? addr1 : addr0;
            cmd_len    <= LEN_M1;
            cmd_valid  <= 1'b1;
            state      <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            wd_valid  <= 1'b1;
            beat      <= '0;
            wd_last   <= (BURST_LEN == 1);
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wd_ready) begin
            if (wd_last) begin
              wd_valid <= 1'b0;
              wd_last  <= 1'b0;
              beat     <= '0;
              state    <= ST_IDLE;
            end else begin
              beat    <= beat + BEAT_W'(1);
              wd_last <= ((beat + BEAT_W'(1)) == LAST_BEAT);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cmos_wr_arbiter.md
CMOS_WR_ARBITER -- requirements
Module: cmos_wr_arbiter

Interface
REQ-001 SHALL have parameters: BURST_LEN, 16, beats per write burst; FRAME_BYTES, 1843200, bytes per frame (1280x720x2); CH0_BASE, 28'h0000000, ch0 buffer-0 byte address; CH1_BASE, 28'h0400000, ch1 buffer-0 byte address; BUF_STRIDE, 28'h0200000, byte offset from buffer 0 to buffer 1.
REQ-002 SHALL have ports: clk in 1 system clock; rst in 1 asynchronous active-high reset.
REQ-003 SHALL have per channel N=0,1: chN_en in 1 channel enable; chN_frame_start in 1 one-cycle frame-start pulse (already in clk domain); chN_fifo_cnt in 11 words in pixel FIFO; chN_rd_data in 16 FWFT FIFO head word (RGB565); chN_rd_en out 1 FIFO pop; chN_buf out 1 index of last completed buffer; chN_ovf out 1 sticky frame-overrun flag.
REQ-004 SHALL have command ports: cmd_valid out 1; cmd_ready in 1; cmd_addr out 28 byte address; cmd_len out 8 beats minus one.
REQ-005 SHALL have data ports: wd_valid out 1; wd_ready in 1; wd_data out 16; wd_last out 1 final beat of burst.
REQ-006 Clock is clk, reset is rst: one clock; reset asynchronous, active-high.

Function
REQ-007 Channel eligible when chN_en=1, chN_fifo_cnt>=BURST_LEN, channel offset+2*BURST_LEN<=FRAME_BYTES, and no frame-start pending for it.
REQ-008 FSM states IDLE, CMD, DATA; IDLE->CMD when any channel eligible (grant registered that cycle); CMD->DATA on cmd_valid&cmd_ready; DATA->IDLE on beat with wd_last.
REQ-009 Arbitration round-robin: both eligible -> grant channel not granted last; one eligible -> grant it; last-grant reset value 1 (ch0 wins first tie).
REQ-010 CMD: cmd_valid=1; cmd_addr=base(N)+chN_bufsel*BUF_STRIDE+offset(N); cmd_len=BURST_LEN-1; held stable until cmd_ready.
REQ-011 DATA: wd_valid=1; wd_data=granted chN_rd_data combinationally; chN_rd_en=wd_valid&wd_ready for granted channel only; other channel rd_en=0.
REQ-012 Beat counter 0..BURST_LEN-1 advances per wd_valid&wd_ready; wd_last=1 when counter=BURST_LEN-1.
REQ-013 On last beat, granted channel offset += 2*BURST_LEN bytes; offset 21 bits, never wraps.
REQ-014 Channel reaching offset=FRAME_BYTES stays ineligible until frame start; chN_ovf sets if chN_fifo_cnt>=BURST_LEN in that condition; cleared only by reset.
REQ-015 chN_frame_start with channel idle or not granted: next cycle offset=0, write buffer toggles, chN_buf=previous write buffer.
REQ-016 chN_frame_start while channel in CMD or DATA: pending flag set; burst completes unchanged; frame-start action (REQ-015) applied the cycle after DATA->IDLE; pending blocks re-grant.
REQ-017 chN_frame_start while chN_en=0: still toggles buffer and clears offset.
REQ-018 cmd_ready or wd_ready low: FSM holds; no output changes; no FIFO pop.
REQ-019 Minimum IDLE dwell one cycle between bursts.

Reset
REQ-020 On rst: state IDLE; cmd_valid=0, wd_valid=0, wd_last=0, chN_rd_en=0, cmd_addr=0, cmd_len=0; offsets 0; write buffer 0; chN_buf=1; chN_ovf=0; pending flags 0.
REQ-021 rst mid-burst aborts immediately; no completion of burst; memory side handles truncated burst.

Structure
REQ-022 BURST_LEN, FRAME_BYTES, base/stride constants and FSM state encoding SHALL live in shared package cmos_pkg.
REQ-023 Per-channel address/buffer/ovf bookkeeping SHALL be sub-module cmos_wr_chan_ctx, instantiated twice; FSM and arbiter in top.

Verification
REQ-024 ch0 cnt=16, ch1 cnt=0, ready always 1 -> cmd_addr=0x0000000, 16 beats, wd_last on beat 16, next ch0 cmd_addr=0x0000020.
REQ-025 both cnt=64 constantly -> grants alternate ch0,ch1,ch0,ch1; ch1 first addr 0x0400000.
REQ-026 wd_ready toggling 1/0 -> exactly 16 pops, data order matches FIFO, wd_last once.
REQ-027 ch0 frame_start during DATA beat 5 -> burst finishes at old address; next ch0 cmd_addr=0x0200000; ch0_buf=0.
REQ-028 ch1 fed 57600 bursts without frame_start, cnt>=16 -> no further ch1 cmd; ch1_ovf=1; frame_start -> ch1 resumes at 0x0600000.
REQ-029 rst asserted in CMD -> cmd_valid drops asynchronously; after release, first cmd at base address buffer 0.
